// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART system controllers: command bytes,
// ALU operand addresses and the RX frame-decoder state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_REG_WR  = 8'hAA;
  localparam logic [7:0] CMD_REG_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OPA,
    ST_OPB,
    ST_FUN,
    ST_ALU_WAIT
  } rx_state_e;

  // The ALU clock must run from the first operand byte until the result returns.
  function automatic logic alu_clk_needed(rx_state_e s);
    return (s == ST_OPA) || (s == ST_OPB) || (s == ST_FUN) || (s == ST_ALU_WAIT);
  endfunction

endpackage

// File: rtl/sys_rx_ctrl.sv
// UART RX-side system controller: decodes command frames into register-file
// and ALU requests, and hands read data / ALU results to the TX controller.
module sys_rx_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data_in,
  input  logic                    rx_data_valid,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_data_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    alu_en,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                    clk_gate_en,
  output logic                    tx_reg_send,
  output logic                    tx_alu_send,
  output logic [DATA_WIDTH-1:0]   reg_data_tx,
  output logic [2*DATA_WIDTH-1:0] alu_data_tx
);

  rx_state_e                state_q, state_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]    address_q, address_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     alu_en_q, alu_en_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
  logic                     clk_gate_en_q, clk_gate_en_d;
  logic                     tx_reg_send_q, tx_reg_send_d;
  logic                     tx_alu_send_q, tx_alu_send_d;
  logic [DATA_WIDTH-1:0]    reg_data_tx_q, reg_data_tx_d;
  logic [2*DATA_WIDTH-1:0]  alu_data_tx_q, alu_data_tx_d;

  always_comb begin
    state_d       = state_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    alu_en_d      = 1'b0;
    tx_reg_send_d = 1'b0;
    tx_alu_send_d = 1'b0;
    address_d     = address_q;
    wr_data_d     = wr_data_q;
    alu_fun_d     = alu_fun_q;
    reg_data_tx_d = reg_data_tx_q;
    alu_data_tx_d = alu_data_tx_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (rx_data_in == DATA_WIDTH'(CMD_REG_WR))       state_d = ST_WR_ADDR;
          else if (rx_data_in == DATA_WIDTH'(CMD_REG_RD))  state_d = ST_RD_ADDR;
          else if (rx_data_in == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OPA;
          else if (rx_data_in == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (rx_data_valid) begin
          address_d = rx_data_in[ADDR_WIDTH-1:0];
          state_d   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (rx_data_valid) begin
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (rx_data_valid) begin
          address_d = rx_data_in[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // Incoming bytes are discarded here; only the read response moves on.
        if (rd_data_valid) begin
          reg_data_tx_d = rd_data;
          tx_reg_send_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_OPA: begin
        if (rx_data_valid) begin
          address_d = ADDR_WIDTH'(OPA_ADDR);
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
          state_d   = ST_OPB;
        end
      end
      ST_OPB: begin
        if (rx_data_valid) begin
          address_d = ADDR_WIDTH'(OPB_ADDR);
          wr_data_d = rx_data_in;
          wr_en_d   = 1'b1;
          state_d   = ST_FUN;
        end
      end
      ST_FUN: begin
        if (rx_data_valid) begin
          alu_fun_d = rx_data_in[ALU_FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (alu_out_valid) begin
          alu_data_tx_d = alu_out;
          tx_alu_send_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so the gate enable is glitch-free yet
    // still tracks the current state cycle for cycle.
    clk_gate_en_d = alu_clk_needed(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      address_q     <= '0;
      wr_data_q     <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_reg_send_q <= 1'b0;
      tx_alu_send_q <= 1'b0;
      reg_data_tx_q <= '0;
      alu_data_tx_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      address_q     <= address_d;
      wr_data_q     <= wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_reg_send_q <= tx_reg_send_d;
      tx_alu_send_q <= tx_alu_send_d;
      reg_data_tx_q <= reg_data_tx_d;
      alu_data_tx_q <= alu_data_tx_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign address     = address_q;
  assign wr_data     = wr_data_q;
  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign clk_gate_en = clk_gate_en_q;
  assign tx_reg_send = tx_reg_send_q;
  assign tx_alu_send = tx_alu_send_q;
  assign reg_data_tx = reg_data_tx_q;
  assign alu_data_tx = alu_data_tx_q;

endmodule

// File: tb/tb_sys_rx_ctrl.sv
// Scoreboard bench for sys_rx_ctrl: directed frames push expected output
// events; a negedge monitor pops and compares each event the DUT produces.
module tb_sys_rx_ctrl;

  typedef enum int {EV_WR, EV_RD, EV_ALU, EV_TXR, EV_TXA} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  a;
    logic [15:0] b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_in;
  logic        rx_data_valid;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        wr_en, rd_en, alu_en, clk_gate_en, tx_reg_send, tx_alu_send;
  logic [3:0]  address;
  logic [7:0]  wr_data;
  logic [3:0]  alu_fun;
  logic [7:0]  reg_data_tx;
  logic [15:0] alu_data_tx;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  sys_rx_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data_in(rx_data_in), .rx_data_valid(rx_data_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .wr_en(wr_en), .rd_en(rd_en), .address(address), .wr_data(wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
    .tx_reg_send(tx_reg_send), .tx_alu_send(tx_alu_send),
    .reg_data_tx(reg_data_tx), .alu_data_tx(alu_data_tx)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [7:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [7:0] a, input logic [15:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d a=0x%0h b=0x%0h expected none at %0t",
               k, a, b, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 16'(k), 16'(e.kind));
      chk("event_a", {8'h00, a}, {8'h00, e.a});
      chk("event_b", b, e.b);
    end
  endtask

  // Monitor: every strobe or send pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en)       observe(EV_WR,  {4'h0, address}, {8'h00, wr_data});
      if (rd_en)       observe(EV_RD,  {4'h0, address}, 16'h0000);
      if (alu_en)      observe(EV_ALU, {4'h0, alu_fun}, 16'h0000);
      if (tx_reg_send) observe(EV_TXR, 8'h00, {8'h00, reg_data_tx});
      if (tx_alu_send) observe(EV_TXA, 8'h00, alu_data_tx);
      if (tx_reg_send && tx_alu_send) chk("send_exclusive", 16'h1, 16'h0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_in    = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] v);
    @(negedge clk);
    rd_data       = v;
    rd_data_valid = 1'b1;
    @(negedge clk);
    rd_data_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] v);
    @(negedge clk);
    alu_out       = v;
    alu_out_valid = 1'b1;
    @(negedge clk);
    alu_out_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, {15'h0, wr_en}, 16'h0);
    chk({tag, "_rd_en"}, {15'h0, rd_en}, 16'h0);
    chk({tag, "_address"}, {12'h0, address}, 16'h0);
    chk({tag, "_wr_data"}, {8'h0, wr_data}, 16'h0);
    chk({tag, "_alu_en"}, {15'h0, alu_en}, 16'h0);
    chk({tag, "_alu_fun"}, {12'h0, alu_fun}, 16'h0);
    chk({tag, "_clk_gate_en"}, {15'h0, clk_gate_en}, 16'h0);
    chk({tag, "_tx_sends"}, {14'h0, tx_reg_send, tx_alu_send}, 16'h0);
    chk({tag, "_reg_data_tx"}, {8'h0, reg_data_tx}, 16'h0);
    chk({tag, "_alu_data_tx"}, alu_data_tx, 16'h0);
  endtask

  initial begin
    rst = 1'b0;
    rx_data_in = 8'h00; rx_data_valid = 1'b0;
    rd_data = 8'h00;    rd_data_valid = 1'b0;
    alu_out = 16'h0000; alu_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Register write
    expect_ev(EV_WR, 8'h05, 16'h003C);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);

    // Register read with dropped bytes and a stray ALU valid while waiting
    expect_ev(EV_RD, 8'h07, 16'h0000);
    send_byte(8'hBB); send_byte(8'h07);
    chk("rd_wait_cg", {15'h0, clk_gate_en}, 16'h0);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    pulse_alu(16'hBEEF);
    expect_ev(EV_TXR, 8'h00, 16'h005A);
    pulse_rd(8'h5A);
    chk("reg_data_tx_after_read", {8'h0, reg_data_tx}, 16'h005A);

    // Read response outside RD_WAIT is ignored
    pulse_rd(8'hEE);
    repeat (2) @(negedge clk);
    chk("reg_data_tx_hold_idle", {8'h0, reg_data_tx}, 16'h005A);

    // ALU op with operands, plus dropped bytes and stray read valid in ALU_WAIT
    send_byte(8'hCC);
    chk("cg_opa", {15'h0, clk_gate_en}, 16'h1);
    expect_ev(EV_WR, 8'h00, 16'h0012);
    send_byte(8'h12);
    chk("cg_opb", {15'h0, clk_gate_en}, 16'h1);
    expect_ev(EV_WR, 8'h01, 16'h0034);
    send_byte(8'h34);
    chk("cg_fun", {15'h0, clk_gate_en}, 16'h1);
    expect_ev(EV_ALU, 8'h02, 16'h0000);
    send_byte(8'h02);
    chk("cg_alu_wait", {15'h0, clk_gate_en}, 16'h1);
    send_byte(8'hBB); send_byte(8'h03);
    pulse_rd(8'h77);
    chk("cg_still_waiting", {15'h0, clk_gate_en}, 16'h1);
    expect_ev(EV_TXA, 8'h00, 16'h0046);
    pulse_alu(16'h0046);
    chk("cg_after_alu", {15'h0, clk_gate_en}, 16'h0);
    chk("alu_data_tx", alu_data_tx, 16'h0046);
    chk("reg_data_tx_hold_alu", {8'h0, reg_data_tx}, 16'h005A);

    // ALU op without operands; upper FUN bits are discarded
    expect_ev(EV_ALU, 8'h08, 16'h0000);
    send_byte(8'hDD); send_byte(8'hF8);
    expect_ev(EV_TXA, 8'h00, 16'h0100);
    pulse_alu(16'h0100);
    repeat (2) @(negedge clk);
    chk("alu_fun_held", {12'h0, alu_fun}, 16'h0008);

    // Garbage byte in IDLE, then a write proves the FSM stayed in IDLE
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    expect_ev(EV_WR, 8'h06, 16'h0077);
    send_byte(8'hAA); send_byte(8'h16); send_byte(8'h77);

    // Reset mid-frame abandons the write to address 3
    send_byte(8'hAA); send_byte(8'h03);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    expect_ev(EV_WR, 8'h04, 16'h0099);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h99);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_rx_ctrl.md
# sys_rx_ctrl

UART receive-side system controller. Consumes bytes from the UART RX path, decodes command frames, and issues register-file writes and reads, ALU operations, and ALU clock-gate enables. It hands read data and ALU results to the TX-side system controller through a send-pulse plus held-data interface. It sits between the RX data synchronizer and the register file, ALU and clock gate.

## Interface
- DATA_WIDTH, 8, byte width of UART data and register-file data
- ADDR_WIDTH, 4, register-file address width
- ALU_FUN_WIDTH, 4, ALU function code width
- clk  in  1  system (REF) clock
- rst  in  1  reset, asynchronous, active-low
- rx_data_in  in  DATA_WIDTH  received byte, valid only with rx_data_valid
- rx_data_valid  in  1  single-cycle pulse per received byte
- rd_data  in  DATA_WIDTH  register-file read data
- rd_data_valid  in  1  single-cycle pulse, rd_data valid
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_out_valid  in  1  single-cycle pulse, alu_out valid
- wr_en  out  1  register-file write strobe
- rd_en  out  1  register-file read strobe
- address  out  ADDR_WIDTH  register-file address
- wr_data  out  DATA_WIDTH  register-file write data
- alu_en  out  1  ALU start strobe
- alu_fun  out  ALU_FUN_WIDTH  ALU function code
- clk_gate_en  out  1  ALU clock-gate enable
- tx_reg_send  out  1  pulse: reg_data_tx ready for transmission
- tx_alu_send  out  1  pulse: alu_data_tx ready for transmission
- reg_data_tx  out  DATA_WIDTH  held register read data
- alu_data_tx  out  2*DATA_WIDTH  held ALU result

## Operation

**Frames.** The first byte of each frame is the command byte.
- 0xAA: register write. Frame is CMD, ADDR, DATA.
- 0xBB: register read. Frame is CMD, ADDR.
- 0xCC: ALU operation with operands. Frame is CMD, OPA, OPB, FUN.
- 0xDD: ALU operation without operands. Frame is CMD, FUN.
- Any other byte in IDLE is dropped and the FSM stays in IDLE.

**States and transitions.** Each transition below occurs on an rx_data_valid byte unless another condition is named.
- IDLE → WR_ADDR, RD_ADDR, OPA or FUN, according to the command byte.
- WR_ADDR → WR_DATA. Latch the address.
- WR_DATA → IDLE. Write the byte to the latched address.
- RD_ADDR → RD_WAIT. Issue the read.
- RD_WAIT → IDLE on rd_data_valid. Capture rd_data and send it.
- OPA → OPB. Write the byte to address 0.
- OPB → FUN. Write the byte to address 1.
- FUN → ALU_WAIT. Issue alu_en with alu_fun set to the byte.
- ALU_WAIT → IDLE on alu_out_valid. Capture alu_out and send it.

**Width rules.**
- address takes the ADDR_WIDTH LSBs of the address byte.
- alu_fun takes the ALU_FUN_WIDTH LSBs of the FUN byte.

**Clock gating.** clk_gate_en = 1 in states OPA, OPB, FUN and ALU_WAIT.

**Dropped bytes.** Bytes arriving in RD_WAIT or ALU_WAIT are dropped. No queueing.

## Timing

**Reset.** Reset drives every output to 0 and the FSM to IDLE. A reset mid-frame abandons the frame; the next byte is decoded as a command.

**Register-file strobes.** wr_en and rd_en are registered, one-cycle pulses, asserted in the cycle after the triggering rx_data_valid. address and wr_data are valid in the same cycle as the strobe.

**ALU strobe.**
- alu_en is a one-cycle pulse, asserted in the cycle after the FUN byte.
- alu_fun is held until the next FUN byte.

**Send pulses.**
- tx_reg_send and tx_alu_send are one-cycle pulses, asserted in the cycle after rd_data_valid or alu_out_valid respectively.
- The matching holding register (reg_data_tx or alu_data_tx) updates in the same cycle as its send pulse.
- Each holding register is held stable until the next capture, because the TX controller reads it over several cycles.

**Simultaneous events.**
- rd_data_valid or alu_out_valid outside its matching wait state is ignored.
- The two send pulses are never asserted in the same cycle.

**Latency.**
- Register read: rd_data_valid to tx_reg_send is 1 cycle.
- ALU: alu_out_valid to tx_alu_send is 1 cycle.

## Structure
- Shared package `sys_ctrl_pkg` holds:
  - command constants CMD_REG_WR = 0xAA, CMD_REG_RD = 0xBB, CMD_ALU_OP = 0xCC, CMD_ALU_NOP = 0xDD
  - operand addresses OPA_ADDR = 0 and OPB_ADDR = 1
  - the RX FSM state encoding
- The block is a single module. No sub-module: the FSM, strobe registers and holding registers form one unit.

## Test plan
- Bytes AA, 05, 3C → one wr_en pulse with address = 5 and wr_data = 0x3C. No send pulse.
- Bytes BB, 07, then rd_data = 0x5A with rd_data_valid → rd_en pulse with address = 7, then tx_reg_send for one cycle. reg_data_tx = 0x5A and stays 0x5A until the next read.
- Bytes CC, 12, 34, 02, then alu_out = 0x0046 with alu_out_valid → writes 0x12 to address 0 and 0x34 to address 1, then an alu_en pulse with alu_fun = 2. clk_gate_en is high from the first cycle in OPA through ALU_WAIT. Finally tx_alu_send with alu_data_tx = 0x0046.
- Bytes DD, 08 → alu_en with alu_fun = 8 and no wr_en. Garbage byte 0x11 in IDLE → no output activity.
- Bytes AA, 03, then rst low, then AA, 04, 99 → no write to address 3. All outputs 0 during reset. The frame after reset writes 0x99 to address 4.
- rx_data_valid pulses during ALU_WAIT and RD_WAIT → bytes dropped, no wr_en or rd_en, FSM waits for the matching valid.
